// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute,
// NZCV flag register and condition gating of every architectural write.
module multicycle_controller (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ALUControl,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [3:0]   State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q;
    logic        condex, condex_q;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];

    // Rn is only a datapath read address; the controller never looks at it.
    logic unused_rn;
    assign unused_rn = ^Instr[19:16];

    logic        regw, memw, branch, alu_op, ir_w, fetch_pcw;
    logic [1:0]  alu_ctl, flag_w;
    logic        exec, pcs;

    assign exec = (state_q == S_EXECR) || (state_q == S_EXECI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                condex_q <= condex;
            if (exec && flag_w[1] && condex_q)
                flags_q[3:2] <= ALUFlags[3:2];
            if (exec && flag_w[0] && condex_q)
                flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode; write strobes are gated further below.
    always_comb begin
        fetch_pcw = 1'b0;
        ir_w      = 1'b0;
        regw      = 1'b0;
        memw      = 1'b0;
        branch    = 1'b0;
        alu_op    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                fetch_pcw = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                memw   = 1'b1;
            end
            S_EXECR:  alu_op = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            S_ALUWB:  regw = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: begin
                ir_w      = 1'b1;
                fetch_pcw = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
        endcase
    end

    // Unrecognised DP codes fall back to ADD and never touch the flags.
    always_comb begin
        alu_ctl = 2'b00;
        flag_w  = 2'b00;
        case (funct[4:1])
            4'b0100: begin alu_ctl = 2'b00; flag_w = {funct[0], funct[0]}; end
            4'b0010: begin alu_ctl = 2'b01; flag_w = {funct[0], funct[0]}; end
            4'b0000: begin alu_ctl = 2'b10; flag_w = {funct[0], 1'b0};     end
            4'b1100: begin alu_ctl = 2'b11; flag_w = {funct[0], 1'b0};     end
            default: begin alu_ctl = 2'b00; flag_w = 2'b00;                end
        endcase
    end

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        condex = 1'b0;
        case (cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign pcs        = branch | (regw & (rd == 4'b1111));
    assign PCWrite    = ~reset & (fetch_pcw | (pcs & condex_q));
    assign IRWrite    = ~reset & ir_w;
    assign RegWrite   = ~reset & regw & condex_q;
    assign MemWrite   = ~reset & memw & condex_q;
    assign ALUControl = alu_op ? alu_ctl : 2'b00;
    assign ImmSrc     = (op == 2'b11) ? 2'b00 : op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign State      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios plus random instruction
// streams checked against an instruction-level model of paths, writes and flags.
module tb_multicycle_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]   ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]   State;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] o_st[8];
    logic       o_pcw[8], o_regw[8], o_memw[8], o_irw[8], o_adr[8];
    logic [1:0] o_res[8], o_srcb[8], o_alu[8], o_imm[8], o_rsrc[8];
    int         n_cyc;
    logic [3:0] m_flags;

    // Runs one instruction from FETCH until State returns to 0 (max 8 cycles),
    // recording what the DUT showed in each cycle.
    task automatic run_instr(input logic [31:0] word, input logic [3:0] af);
        Instr    = word[31:12];
        ALUFlags = af;
        n_cyc    = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            o_st[k] = State;   o_pcw[k] = PCWrite; o_regw[k] = RegWrite;
            o_memw[k] = MemWrite; o_irw[k] = IRWrite; o_adr[k] = AdrSrc;
            o_res[k] = ResultSrc; o_srcb[k] = ALUSrcB; o_alu[k] = ALUControl;
            o_imm[k] = ImmSrc; o_rsrc[k] = RegSrc;
            n_cyc = k + 1;
            @(posedge clk);
            @(negedge clk);
            if (State == 4'd0) break;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Instr = '0;
        ALUFlags = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
    endtask

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;        4'h1: return !z;
            4'h2: return cy;       4'h3: return !cy;
            4'h4: return n;        4'h5: return !n;
            4'h6: return v;        4'h7: return !v;
            4'h8: return cy && !z; 4'h9: return !cy || z;
            4'hA: return n == v;   4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        Instr = 20'hE2802;
        ALUFlags = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (State !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 ||
            RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_writes: state=%0d pcw=%b irw=%b regw=%b memw=%b expected state=0 all writes 0",
                     State, PCWrite, IRWrite, RegWrite, MemWrite);
        end
        checks++;
        if (AdrSrc !== 1'b0 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin
            errors++;
            $display("FAIL reset_muxes: adr=%b srca=%b srcb=%b res=%b expected 0 1 10 10",
                     AdrSrc, ALUSrcA, ALUSrcB, ResultSrc);
        end
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
        #1;
        checks++;
        if (PCWrite !== 1'b1 || IRWrite !== 1'b1) begin
            errors++;
            $display("FAIL fetch_after_reset: pcw=%b irw=%b expected 1 1", PCWrite, IRWrite);
        end
    endtask

    task automatic test_add_imm();
        run_instr(32'hE2802005, 4'b0000);
        checks++;
        if (n_cyc !== 4 || o_st[0] !== 4'd0 || o_st[1] !== 4'd1 || o_st[2] !== 4'd7 || o_st[3] !== 4'd8) begin
            errors++;
            $display("FAIL add_path: len=%0d states=%0d,%0d,%0d,%0d expected 4 0,1,7,8",
                     n_cyc, o_st[0], o_st[1], o_st[2], o_st[3]);
        end
        checks++;
        if (o_srcb[2] !== 2'b01 || o_alu[2] !== 2'b00) begin
            errors++;
            $display("FAIL add_execi: srcb=%b alu=%b expected 01 00", o_srcb[2], o_alu[2]);
        end
        checks++;
        if ({o_regw[0], o_regw[1], o_regw[2], o_regw[3]} !== 4'b0001 ||
            {o_pcw[0], o_pcw[1], o_pcw[2], o_pcw[3]} !== 4'b1000) begin
            errors++;
            $display("FAIL add_writes: regw=%b%b%b%b pcw=%b%b%b%b expected 0001 1000",
                     o_regw[0], o_regw[1], o_regw[2], o_regw[3], o_pcw[0], o_pcw[1], o_pcw[2], o_pcw[3]);
        end
    endtask

    task automatic test_subs_addeq();
        run_instr(32'hE0537003, 4'b0110);
        checks++;
        if (n_cyc !== 4 || o_st[2] !== 4'd6 || o_alu[2] !== 2'b01 || o_srcb[2] !== 2'b00) begin
            errors++;
            $display("FAIL subs_exec: len=%0d state=%0d alu=%b srcb=%b expected 4 6 01 00",
                     n_cyc, o_st[2], o_alu[2], o_srcb[2]);
        end
        run_instr(32'h02822001, 4'b0000);
        checks++;
        if (o_regw[3] !== 1'b1 || o_st[3] !== 4'd8) begin
            errors++;
            $display("FAIL addeq_regwrite: regw=%b state=%0d expected 1 8", o_regw[3], o_st[3]);
        end
        // Z=C=1 from SUBS survives the non-S ADDEQ, so BCS is taken.
        run_instr(32'h2A000001, 4'b0000);
        checks++;
        if (n_cyc !== 3 || o_pcw[2] !== 1'b1) begin
            errors++;
            $display("FAIL bcs_taken: len=%0d pcw=%b expected 3 1", n_cyc, o_pcw[2]);
        end
    endtask

    task automatic test_ldr();
        run_instr(32'hE5902060, 4'b0000);
        checks++;
        if (n_cyc !== 5 || o_st[2] !== 4'd2 || o_st[3] !== 4'd3 || o_st[4] !== 4'd4) begin
            errors++;
            $display("FAIL ldr_path: len=%0d states=%0d,%0d,%0d expected 5 2,3,4",
                     n_cyc, o_st[2], o_st[3], o_st[4]);
        end
        checks++;
        if (o_adr[3] !== 1'b1 || o_res[4] !== 2'b01 || o_regw[4] !== 1'b1 || o_regw[3] !== 1'b0) begin
            errors++;
            $display("FAIL ldr_ctrl: adr=%b res=%b regw_wb=%b regw_rd=%b expected 1 01 1 0",
                     o_adr[3], o_res[4], o_regw[4], o_regw[3]);
        end
    endtask

    task automatic test_str_streq();
        do_reset();
        run_instr(32'hE5837054, 4'b0000);
        checks++;
        if (n_cyc !== 4 || o_st[3] !== 4'd5 || o_memw[3] !== 1'b1 || o_adr[3] !== 1'b1) begin
            errors++;
            $display("FAIL str_memwrite: len=%0d state=%0d memw=%b adr=%b expected 4 5 1 1",
                     n_cyc, o_st[3], o_memw[3], o_adr[3]);
        end
        run_instr(32'h05837054, 4'b0000);
        checks++;
        if (n_cyc !== 4 || ({o_memw[0], o_memw[1], o_memw[2], o_memw[3]} !== 4'b0000)) begin
            errors++;
            $display("FAIL streq_suppressed: len=%0d memw=%b%b%b%b expected 4 0000",
                     n_cyc, o_memw[0], o_memw[1], o_memw[2], o_memw[3]);
        end
    endtask

    task automatic test_branch();
        run_instr(32'hEA000001, 4'b0000);
        checks++;
        if (n_cyc !== 3 || o_st[2] !== 4'd9 || o_pcw[2] !== 1'b1 || o_res[2] !== 2'b10 ||
            o_imm[1] !== 2'b10 || o_rsrc[1] !== 2'b01) begin
            errors++;
            $display("FAIL b_al: len=%0d state=%0d pcw=%b res=%b imm=%b rsrc=%b expected 3 9 1 10 10 01",
                     n_cyc, o_st[2], o_pcw[2], o_res[2], o_imm[1], o_rsrc[1]);
        end
        run_instr(32'h0A000001, 4'b0000);
        checks++;
        if (n_cyc !== 3 || o_pcw[2] !== 1'b0) begin
            errors++;
            $display("FAIL beq_not_taken: len=%0d pcw=%b expected 3 0", n_cyc, o_pcw[2]);
        end
    endtask

    task automatic test_pc_write_and_op11();
        run_instr(32'hE08FF000, 4'b0000);
        checks++;
        if (o_st[3] !== 4'd8 || o_pcw[3] !== 1'b1 || o_regw[3] !== 1'b1) begin
            errors++;
            $display("FAIL add_pc: state=%0d pcw=%b regw=%b expected 8 1 1", o_st[3], o_pcw[3], o_regw[3]);
        end
        run_instr(32'hFC000000, 4'b1111);
        checks++;
        if (n_cyc !== 2 || o_st[1] !== 4'd1 || o_pcw[1] !== 1'b0 || o_regw[1] !== 1'b0 ||
            o_memw[1] !== 1'b0) begin
            errors++;
            $display("FAIL op11: len=%0d state=%0d pcw=%b regw=%b memw=%b expected 2 1 0 0 0",
                     n_cyc, o_st[1], o_pcw[1], o_regw[1], o_memw[1]);
        end
    endtask

    task automatic test_reset_midinstr();
        Instr = 20'hE5837;
        ALUFlags = 4'b0000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
        if (State !== 4'd5 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL reach_memwr: state=%0d memw=%b expected 5 1", State, MemWrite);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || State !== 4'd0) begin
            errors++;
            $display("FAIL reset_abort: memw=%b state=%0d expected 0 0", MemWrite, State);
        end
        @(negedge clk);
        reset = 1'b0;
        m_flags = 4'b0000;
    endtask

    task automatic test_random();
        do_reset();
        for (int it = 0; it < 300; it++) begin
            logic [3:0]  c, rd, af;
            logic [1:0]  op, exp_alu;
            logic [5:0]  fn;
            logic [31:0] word;
            logic        pass, is_dp, is_ldr, is_str, is_b, known, arith;
            int          exp_st[$];
            int          sel;
            c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            op = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            fn = 6'($urandom_range(0, 63));
            if (op == 2'b00) begin
                case ($urandom_range(0, 4))
                    0: fn[4:1] = 4'b0100;
                    1: fn[4:1] = 4'b0010;
                    2: fn[4:1] = 4'b0000;
                    3: fn[4:1] = 4'b1100;
                    default: ;
                endcase
            end
            rd = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            af = 4'($urandom_range(0, 15));
            word = {c, op, fn, 4'($urandom_range(0, 15)), rd, 12'($urandom_range(0, 4095))};

            pass   = cond_ok(c, m_flags);
            is_dp  = (op == 2'b00);
            is_ldr = (op == 2'b01) && fn[0];
            is_str = (op == 2'b01) && !fn[0];
            is_b   = (op == 2'b10);
            exp_st = {0, 1};
            if (is_dp)  exp_st = {exp_st, (fn[5] ? 7 : 6), 8};
            if (is_ldr) exp_st = {exp_st, 2, 3, 4};
            if (is_str) exp_st = {exp_st, 2, 5};
            if (is_b)   exp_st = {exp_st, 9};
            known = 1'b1;
            arith = 1'b0;
            case (fn[4:1])
                4'b0100: begin exp_alu = 2'b00; arith = 1'b1; end
                4'b0010: begin exp_alu = 2'b01; arith = 1'b1; end
                4'b0000: exp_alu = 2'b10;
                4'b1100: exp_alu = 2'b11;
                default: begin exp_alu = 2'b00; known = 1'b0; end
            endcase

            run_instr(word, af);

            checks++;
            if (n_cyc !== exp_st.size()) begin
                errors++;
                $display("FAIL rand_len[%0d] %h: got %0d expected %0d", it, word, n_cyc, exp_st.size());
            end
            for (int k = 0; k < exp_st.size() && k < n_cyc; k++) begin
                logic last, e_pcw, e_regw, e_memw;
                logic [1:0] e_alu, e_imm, e_rsrc;
                last   = (k == exp_st.size() - 1);
                e_regw = last && pass && (is_dp || is_ldr);
                e_memw = last && pass && is_str;
                e_pcw  = (k == 0) || (last && pass && (is_b || ((is_dp || is_ldr) && rd == 4'hF)));
                e_alu  = (is_dp && k == 2) ? exp_alu : 2'b00;
                e_imm  = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
                e_rsrc = {op == 2'b01, op == 2'b10};
                checks++;
                if (o_st[k] !== 4'(exp_st[k]) || o_pcw[k] !== e_pcw || o_regw[k] !== e_regw ||
                    o_memw[k] !== e_memw || o_irw[k] !== (k == 0) || o_alu[k] !== e_alu ||
                    o_imm[k] !== e_imm || o_rsrc[k] !== e_rsrc) begin
                    errors++;
                    $display("FAIL rand_cycle[%0d.%0d] %h: st=%0d pcw=%b regw=%b memw=%b irw=%b alu=%b imm=%b rsrc=%b expected st=%0d pcw=%b regw=%b memw=%b irw=%b alu=%b imm=%b rsrc=%b",
                             it, k, word, o_st[k], o_pcw[k], o_regw[k], o_memw[k], o_irw[k], o_alu[k],
                             o_imm[k], o_rsrc[k], exp_st[k], e_pcw, e_regw, e_memw, (k == 0), e_alu,
                             e_imm, e_rsrc);
                end
            end

            if (is_dp && pass && fn[0] && known) begin
                m_flags[3:2] = af[3:2];
                if (arith) m_flags[1:0] = af[1:0];
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_subs_addeq();
        test_ldr();
        test_str_streq();
        test_branch();
        test_pc_write_and_op11();
        test_reset_midinstr();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
